// File: rtl/clock_pkg.sv
// Shared alarm-clock constants: board clock rate, button timing defaults and
// the button FSM state encoding.
package clock_pkg;

  localparam int unsigned CLK_HZ            = 50_000_000;

  // 0.5 s to the first auto-repeat, then one repeat every 0.1 s at 50 MHz.
  localparam int unsigned DEF_HOLD_CYCLES   = 25_000_000;
  localparam int unsigned DEF_REPEAT_CYCLES = 5_000_000;
  localparam int unsigned DEF_CNT_W         = 25;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESSED = 2'd1,
    ST_REPEAT  = 2'd2
  } btn_state_e;

endpackage : clock_pkg

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input.
//   clock     : destination clock
//   reset_n   : asynchronous active-low reset, both flops load RESET_VAL
//   d         : asynchronous input
//   q         : synchronised output, two clock edges of latency
module sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clock,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic s1_q, s1_d;
  logic s2_q, s2_d;

  // Next values for the two synchroniser stages.
  always_comb begin
    s1_d = d;
    s2_d = s1_q;
  end

  // Synchroniser stages.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s1_q <= RESET_VAL;
      s2_q <= RESET_VAL;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

  assign q = s2_q;

endmodule : sync_2ff

// File: rtl/button_event_gen.sv
// Turns a debounced button level into single-cycle press / release /
// auto-repeat events for the alarm-clock setting logic.
//   clock         : 50 MHz board clock, rising edge
//   reset_n       : asynchronous active-low reset
//   btn_level     : debounced button level (1 = pressed), asynchronous
//   press_pulse   : one-cycle pulse on accepted press
//   release_pulse : one-cycle pulse on accepted release
//   repeat_pulse  : one-cycle pulse per auto-repeat tick
//   step_pulse    : press or repeat, drives increment logic
//   hold_active   : high while auto-repeating
module button_event_gen
  import clock_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES   = DEF_HOLD_CYCLES,
  parameter int unsigned REPEAT_CYCLES = DEF_REPEAT_CYCLES,
  parameter int unsigned CNT_W         = DEF_CNT_W,
  parameter bit          REPEAT_EN     = 1'b1
) (
  input  logic clock,
  input  logic reset_n,
  input  logic btn_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic repeat_pulse,
  output logic step_pulse,
  output logic hold_active
);

  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);

  btn_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              s2;
  logic              s3_q, s3_d;
  logic              rise, fall;
  logic              hold_done, rep_done;
  logic              press_q, press_d;
  logic              release_q, release_d;
  logic              repeat_q, repeat_d;
  logic              step_q, step_d;
  logic              hold_q, hold_d;

  // The debouncer output is launched from a divided clock.
  sync_2ff #(.RESET_VAL(1'b0)) u_sync (
    .clock   (clock),
    .reset_n (reset_n),
    .d       (btn_level),
    .q       (s2)
  );

  // Edge detection against the previous synchronised level.
  always_comb begin
    s3_d      = s2;
    rise      = s2 & ~s3_q;
    fall      = ~s2 & s3_q;
    hold_done = (cnt_q == HOLD_LAST);
    rep_done  = (cnt_q == REPEAT_LAST);
  end

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a fall always takes priority over a terminal count.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (rise) state_d = ST_PRESSED;
      end
      ST_PRESSED: begin
        if (fall)                        state_d = ST_IDLE;
        else if (REPEAT_EN && hold_done) state_d = ST_REPEAT;
      end
      ST_REPEAT: begin
        if (fall) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Event and counter logic.
  always_comb begin
    press_d   = 1'b0;
    release_d = 1'b0;
    repeat_d  = 1'b0;
    cnt_d     = cnt_q;
    case (state_q)
      ST_IDLE: begin
        cnt_d   = '0;
        press_d = rise;
      end
      ST_PRESSED: begin
        if (fall) begin
          release_d = 1'b1;
          cnt_d     = '0;
        end else if (hold_done) begin
          // Without auto-repeat the count parks at its terminal value.
          if (REPEAT_EN) begin
            repeat_d = 1'b1;
            cnt_d    = '0;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_REPEAT: begin
        if (fall) begin
          release_d = 1'b1;
          cnt_d     = '0;
        end else if (rep_done) begin
          repeat_d = 1'b1;
          cnt_d    = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: cnt_d = '0;
    endcase
    step_d = press_d | repeat_d;
    hold_d = (state_d == ST_REPEAT);
  end

  // Counter, edge-detect and output registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q     <= '0;
      s3_q      <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      repeat_q  <= 1'b0;
      step_q    <= 1'b0;
      hold_q    <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      s3_q      <= s3_d;
      press_q   <= press_d;
      release_q <= release_d;
      repeat_q  <= repeat_d;
      step_q    <= step_d;
      hold_q    <= hold_d;
    end
  end

  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign repeat_pulse  = repeat_q;
  assign step_pulse    = step_q;
  assign hold_active   = hold_q;

endmodule : button_event_gen

// File: tb/tb_button_event_gen.sv
// Scoreboard bench: stimulus pushes expected events (cycle + output mask),
// per-instance monitors pop and compare whenever a pulse output is seen.
module tb_button_event_gen;

  typedef struct {
    int         cyc;
    logic [4:0] mask;   // {press, release, repeat, step, hold}
  } exp_t;

  localparam logic [4:0] M_PRESS = 5'b10010;
  localparam logic [4:0] M_REL   = 5'b01000;
  localparam logic [4:0] M_REP_H = 5'b00111;

  logic clock = 1'b0;
  logic reset_n;
  logic btn_a, btn_b;
  logic press_a, release_a, repeat_a, step_a, hold_a;
  logic press_b, release_b, repeat_b, step_b, hold_b;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   step_cnt_a = 0;
  int   hold_cnt_a = 0;
  int   hold_cnt_b = 0;
  int   rep_cnt_b = 0;
  exp_t qa[$];
  exp_t qb[$];

  button_event_gen #(
    .HOLD_CYCLES(8), .REPEAT_CYCLES(4), .CNT_W(4), .REPEAT_EN(1'b1)
  ) dut_a (
    .clock(clock), .reset_n(reset_n), .btn_level(btn_a),
    .press_pulse(press_a), .release_pulse(release_a), .repeat_pulse(repeat_a),
    .step_pulse(step_a), .hold_active(hold_a)
  );

  button_event_gen #(
    .HOLD_CYCLES(8), .REPEAT_CYCLES(4), .CNT_W(4), .REPEAT_EN(1'b0)
  ) dut_b (
    .clock(clock), .reset_n(reset_n), .btn_level(btn_b),
    .press_pulse(press_b), .release_pulse(release_b), .repeat_pulse(repeat_b),
    .step_pulse(step_b), .hold_active(hold_b)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, req);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  function automatic exp_t mk(input int c, input logic [4:0] m);
    exp_t e;
    e.cyc  = c;
    e.mask = m;
    return e;
  endfunction

  // Monitor for the auto-repeat instance.
  always @(negedge clock) begin
    if (reset_n) begin
      if (step_a) step_cnt_a++;
      if (hold_a) hold_cnt_a++;
      if (press_a | release_a | repeat_a | step_a) begin
        if (qa.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_event_a cyc=%0d actual=%b required=none", cyc,
                   {press_a, release_a, repeat_a, step_a, hold_a});
        end else begin
          exp_t e;
          e = qa.pop_front();
          chk("event_a_cycle", 32'(cyc), 32'(e.cyc));
          chk("event_a_mask", 32'({press_a, release_a, repeat_a, step_a, hold_a}), 32'(e.mask));
        end
      end
    end
  end

  // Monitor for the repeat-disabled instance.
  always @(negedge clock) begin
    if (reset_n) begin
      if (hold_b) hold_cnt_b++;
      if (repeat_b) rep_cnt_b++;
      if (press_b | release_b | repeat_b | step_b) begin
        if (qb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_event_b cyc=%0d actual=%b required=none", cyc,
                   {press_b, release_b, repeat_b, step_b, hold_b});
        end else begin
          exp_t e;
          e = qb.pop_front();
          chk("event_b_cycle", 32'(cyc), 32'(e.cyc));
          chk("event_b_mask", 32'({press_b, release_b, repeat_b, step_b, hold_b}), 32'(e.mask));
        end
      end
    end
  end

  initial begin
    int e;
    int r;
    int s0;
    int h0;

    reset_n = 1'b0;
    btn_a   = 1'b0;
    btn_b   = 1'b0;

    // Reset state.
    wait_cycles(3);
    chk("reset_outputs_a", 32'({press_a, release_a, repeat_a, step_a, hold_a}), 32'd0);
    chk("reset_outputs_b", 32'({press_b, release_b, repeat_b, step_b, hold_b}), 32'd0);
    reset_n = 1'b1;
    wait_cycles(3);

    // Single short press: 5 cycles, below the hold time.
    e = cyc;
    qa.push_back(mk(e + 3, M_PRESS));
    qa.push_back(mk(e + 8, M_REL));
    btn_a = 1'b1;
    wait_cycles(5);
    btn_a = 1'b0;
    wait_cycles(10);
    chk("short_press_queue_empty", 32'(qa.size()), 32'd0);

    // Long hold of 30 cycles: press at t, repeats at t+8 .. t+28, release at t+30.
    s0 = step_cnt_a;
    h0 = hold_cnt_a;
    e  = cyc;
    qa.push_back(mk(e + 3, M_PRESS));
    for (int k = 0; k < 6; k++) qa.push_back(mk(e + 11 + 4 * k, M_REP_H));
    qa.push_back(mk(e + 33, M_REL));
    btn_a = 1'b1;
    wait_cycles(30);
    btn_a = 1'b0;
    wait_cycles(10);
    chk("long_hold_queue_empty", 32'(qa.size()), 32'd0);
    chk("long_hold_step_count", 32'(step_cnt_a - s0), 32'd7);
    chk("long_hold_hold_cycles", 32'(hold_cnt_a - h0), 32'd22);

    // Fall coincides with the REPEAT terminal count: release only.
    e = cyc;
    qa.push_back(mk(e + 3, M_PRESS));
    qa.push_back(mk(e + 11, M_REP_H));
    qa.push_back(mk(e + 15, M_REL));
    btn_a = 1'b1;
    wait_cycles(12);
    btn_a = 1'b0;
    wait_cycles(15);
    chk("tc_release_queue_empty", 32'(qa.size()), 32'd0);
    chk("tc_release_hold_low", 32'(hold_a), 32'd0);

    // Repeat disabled: 20-cycle hold, counter parks at HOLD_CYCLES-1.
    e = cyc;
    qb.push_back(mk(e + 3, M_PRESS));
    qb.push_back(mk(e + 23, M_REL));
    btn_b = 1'b1;
    wait_cycles(19);
    chk("no_repeat_cnt_saturated", 32'(dut_b.cnt_q), 32'd7);
    wait_cycles(1);
    btn_b = 1'b0;
    wait_cycles(10);
    chk("no_repeat_queue_empty", 32'(qb.size()), 32'd0);
    chk("no_repeat_repeat_count", 32'(rep_cnt_b), 32'd0);
    chk("no_repeat_hold_cycles", 32'(hold_cnt_b), 32'd0);

    // Asynchronous reset while auto-repeating, button kept held.
    e = cyc;
    qa.push_back(mk(e + 3, M_PRESS));
    qa.push_back(mk(e + 11, M_REP_H));
    btn_a = 1'b1;
    wait_cycles(13);
    chk("pre_reset_hold_high", 32'(hold_a), 32'd1);
    #1;
    reset_n = 1'b0;
    #1;
    chk("async_reset_outputs_a", 32'({press_a, release_a, repeat_a, step_a, hold_a}), 32'd0);
    chk("async_reset_queue_empty", 32'(qa.size()), 32'd0);
    wait_cycles(1);
    r = cyc;
    qa.push_back(mk(r + 3, M_PRESS));
    qa.push_back(mk(r + 8, M_REL));
    reset_n = 1'b1;
    wait_cycles(5);
    btn_a = 1'b0;
    wait_cycles(10);
    chk("post_reset_queue_empty", 32'(qa.size()), 32'd0);

    // One-cycle glitch while idle: a press/release pair and nothing else.
    e = cyc;
    qa.push_back(mk(e + 3, M_PRESS));
    qa.push_back(mk(e + 4, M_REL));
    btn_a = 1'b1;
    wait_cycles(1);
    btn_a = 1'b0;
    wait_cycles(20);
    chk("glitch_queue_empty", 32'(qa.size()), 32'd0);
    chk("glitch_hold_low", 32'(hold_a), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_button_event_gen
